// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer controller of the dual-clock FIFO: binary/gray write pointer,
// decode of the synchronized gray read pointer, occupancy, flags and push handshake.
module fifo_wr_ptr_ctrl #(
    parameter int N         = 4,
    parameter int AF_THRESH = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    output logic         push_rdy,
    output logic         wr_en,
    output logic [N-1:0] wr_addr,
    output logic [N:0]   wr_ptr_gray,
    input  logic [N:0]   rd_ptr_gray_s,
    output logic [N:0]   level,
    output logic         full,
    output logic         almost_full,
    output logic         ptr_err
);

    localparam logic [N:0] DEPTH = (N+1)'(1) << N;
    localparam logic [N:0] AF    = AF_THRESH[N:0];

    typedef enum logic [1:0] {INIT, RUN, ERR} state_t;

    state_t     state, state_nxt;
    logic [N:0] wr_ptr_bin;
    logic [N:0] next_bin;
    logic [N:0] rd_ptr_bin;
    logic       in_run;
    logic       lvl_full;
    logic       lvl_over;

    // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        rd_ptr_bin = '0;
        for (int i = 0; i <= N; i++)
            rd_ptr_bin[i] = ^(rd_ptr_gray_s >> i);
    end

    assign level    = wr_ptr_bin - rd_ptr_bin;
    assign lvl_full = (level == DEPTH);
    assign lvl_over = (level > DEPTH);
    assign in_run   = (state == RUN);

    assign full        = in_run & lvl_full;
    assign almost_full = in_run & (level >= AF);
    assign push_rdy    = in_run & ~lvl_full & ~lvl_over;
    assign wr_en       = push_vld & push_rdy;
    assign wr_addr     = wr_ptr_bin[N-1:0];
    assign ptr_err     = (state == ERR);
    assign next_bin    = wr_ptr_bin + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (rd_ptr_gray_s == '0) state_nxt = RUN;
            RUN:     if (lvl_over)            state_nxt = ERR;
            ERR:     state_nxt = ERR;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Gray is registered from next_bin so the exported bus moves one bit per push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_bin  <= '0;
            wr_ptr_gray <= '0;
        end else if (wr_en) begin
            wr_ptr_bin  <= next_bin;
            wr_ptr_gray <= next_bin ^ (next_bin >> 1);
        end
    end

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Bench for fifo_wr_ptr_ctrl: reference model plus write-address scoreboard.
module tb_fifo_wr_ptr_ctrl;

    logic       clk = 0;
    logic       rst = 1;
    logic       push_vld = 0;
    logic       push_rdy, wr_en, full, almost_full, ptr_err;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr_gray, level;
    logic [4:0] rd_ptr_gray_s = 0;

    fifo_wr_ptr_ctrl #(.N(4), .AF_THRESH(12)) dut (
        .clk(clk), .rst(rst), .push_vld(push_vld), .push_rdy(push_rdy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_ptr_gray(wr_ptr_gray),
        .rd_ptr_gray_s(rd_ptr_gray_s), .level(level), .full(full),
        .almost_full(almost_full), .ptr_err(ptr_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int         m_state;   // 0 INIT, 1 RUN, 2 ERR
    logic [4:0] m_wp;
    logic [3:0] addr_q[$];
    logic [4:0] prev_gray;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check_outputs(output logic acc, output logic over);
        logic [4:0] lvl;
        logic run, f, af, rdy;
        lvl  = m_wp - g2b(rd_ptr_gray_s);
        run  = (m_state == 1);
        over = (lvl > 5'd16);
        f    = run & (lvl == 5'd16);
        af   = run & (lvl >= 5'd12);
        rdy  = run & ~(lvl == 5'd16) & ~over;
        acc  = push_vld & rdy;
        chk("level", level, lvl);
        chk("full", full, f);
        chk("almost_full", almost_full, af);
        chk("push_rdy", push_rdy, rdy);
        chk("wr_en", wr_en, acc);
        chk("ptr_err", ptr_err, m_state == 2);
        chk("wr_ptr_gray", wr_ptr_gray, b2g(m_wp));
        if (acc) addr_q.push_back(m_wp[3:0]);
        if (wr_en) begin
            if (addr_q.size() == 0) chk("unexpected_wr", 1, 0);
            else chk("wr_addr", wr_addr, addr_q.pop_front());
        end
    endtask

    // Called just after a falling edge; compares, then advances the model at the rising edge.
    task automatic cyc(input logic pv, input logic [4:0] rg);
        logic acc, over;
        push_vld      = pv;
        rd_ptr_gray_s = rg;
        #1;
        check_outputs(acc, over);
        @(posedge clk);
        case (m_state)
            0: if (rg == 0) m_state = 1;
            1: if (over) m_state = 2;
            default: ;
        endcase
        if (acc) m_wp = m_wp + 1;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [4:0] rg);
        rst = 1;
        rd_ptr_gray_s = rg;
        #1;
        m_state = 0;
        m_wp    = 0;
        addr_q.delete();
        chk("rst_push_rdy", push_rdy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_ptr_gray", wr_ptr_gray, 0);
        chk("rst_full", full, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_ptr_err", ptr_err, 0);
        chk("rst_level", level, 5'(0 - g2b(rg)));
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        m_state = 0;
        m_wp    = 0;
        @(negedge clk);
        do_reset(5'd0);

        // INIT for one edge, then RUN
        cyc(0, 5'd0);
        cyc(0, 5'd0);
        chk("run_rdy", push_rdy, 1);

        // Fill to full with read pointer at 0
        for (int i = 0; i < 17; i++) cyc(1, 5'd0);
        chk("full_gray", wr_ptr_gray, 5'b11000);
        chk("full_flag", full, 1);

        // One read frees a slot in the same cycle
        cyc(1, 5'b00001);
        chk("refill_full", full, 1);

        // Wrap: reader tracks writer - 2, gray must change one bit per step
        prev_gray = wr_ptr_gray;
        for (int i = 0; i < 40; i++) begin
            cyc(1, b2g(m_wp - 5'd2));
            chk("gray_onebit", $countones(prev_gray ^ wr_ptr_gray), 1);
            prev_gray = wr_ptr_gray;
        end
        while (m_wp != 5'd2) cyc(1, b2g(m_wp - 5'd2));
        cyc(0, b2g(5'd20));
        chk("lvl14_a", level, 14);
        while (m_wp != 5'd0) cyc(1, b2g(m_wp - 5'd2));
        cyc(0, b2g(5'd18));
        chk("lvl14_b", level, 14);

        // Overflow relationship -> sticky error
        cyc(1, b2g(5'd15));
        for (int i = 0; i < 4; i++) cyc(1, 5'd0);
        chk("err_sticky", ptr_err, 1);

        // Mid-operation reset at level 7 with push_vld high
        do_reset(5'd0);
        cyc(0, 5'd0);
        for (int i = 0; i < 7; i++) cyc(1, 5'd0);
        chk("lvl7", level, 7);
        push_vld = 1;
        do_reset(5'd0);
        for (int i = 0; i < 3; i++) cyc(1, b2g(5'd3));
        chk("init_hold_rdy", push_rdy, 0);
        cyc(1, 5'd0);
        cyc(1, 5'd0);
        chk("queue_empty", addr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=1 expected=0");
        $fatal(1);
    end

endmodule
